// File: rtl/fir_sample_source.sv
// Stimulus source for the FIR filter sample port: emits impulse/step/ramp/LFSR bursts at a programmed cadence.
// Define FIR_SOURCE_CONTINUOUS_EN to make count=0 an endless burst (otherwise count=0 yields a bare done pulse).
module fir_sample_source #(
    parameter int          WIDTH     = 24,
    parameter logic [23:0] LFSR_SEED = 24'hACE1F5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic [15:0]             period,
    input  logic [15:0]             count,
    input  logic signed [WIDTH-1:0] amplitude,
    output logic signed [WIDTH-1:0] input_sig,
    output logic                    ready,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [15:0]             div;
    logic [15:0]             k;
    logic [23:0]             lfsr;
    logic signed [WIDTH-1:0] ramp_r;
    logic [1:0]              mode_r;
    logic [15:0]             period_r;
    logic [15:0]             count_r;
    logic signed [WIDTH-1:0] amp_r;
    logic                    burst_end;
    logic                    zero_count;

    // Galois form of x^24+x^23+x^22+x^17+1, shifting toward bit 0.
    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
    endfunction

    function automatic logic signed [WIDTH-1:0] lfsr_sample(input logic [23:0] s);
        logic signed [23:0] v;
        v = s;
        lfsr_sample = WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] pattern(
        input logic [1:0]              m,
        input logic                    first,
        input logic signed [WIDTH-1:0] amp,
        input logic signed [WIDTH-1:0] ramp,
        input logic [23:0]             s
    );
        case (m)
            2'd0:    pattern = first ? amp : '0;
            2'd1:    pattern = amp;
            2'd2:    pattern = ramp;
            default: pattern = lfsr_sample(s);
        endcase
    endfunction

`ifdef FIR_SOURCE_CONTINUOUS_EN
    assign burst_end  = (count_r != 16'd0) && (k == count_r);
    assign zero_count = 1'b0;
`else
    assign burst_end  = (k == count_r);
    assign zero_count = (count == 16'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div       <= '0;
            k         <= '0;
            lfsr      <= LFSR_SEED;
            input_sig <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            ready <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        period_r <= period;
                        count_r  <= count;
                        amp_r    <= amplitude;
                        div      <= '0;
                        if (zero_count) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            k      <= '0;
                            lfsr   <= LFSR_SEED;
                            ramp_r <= amplitude;
                        end else begin
                            // Sample 0 goes out on the first RUN cycle, so it is produced here.
                            state     <= RUN;
                            busy      <= 1'b1;
                            ready     <= 1'b1;
                            input_sig <= pattern(mode, 1'b1, amplitude, amplitude, LFSR_SEED);
                            lfsr      <= lfsr_next(LFSR_SEED);
                            ramp_r    <= amplitude + WIDTH'(1);
                            k         <= 16'd1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (burst_end) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (div == period_r) begin
                        div       <= '0;
                        ready     <= 1'b1;
                        input_sig <= pattern(mode_r, 1'b0, amp_r, ramp_r, lfsr);
                        lfsr      <= lfsr_next(lfsr);
                        ramp_r    <= ramp_r + WIDTH'(1);
                        k         <= k + 16'd1;
                    end else begin
                        div <= div + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed bench for fir_sample_source: reset, all four patterns, cadence, abort, reset mid-burst, count=0.
module tb_fir_sample_source;

    localparam int WIDTH = 24;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [15:0]      period;
    logic [15:0]      count;
    logic [WIDTH-1:0] amplitude;
    logic [WIDTH-1:0] input_sig;
    logic             ready;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;

    fir_sample_source #(.WIDTH(WIDTH), .LFSR_SEED(24'hACE1F5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .count     (count),
        .amplitude (amplitude),
        .input_sig (input_sig),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [23:0] imp_exp  [4];
    logic [23:0] ramp_exp [4];
    logic [23:0] lfsr_exp [3];

    initial begin
        int idx;
        imp_exp  = '{24'h100000, 24'h000000, 24'h000000, 24'h000000};
        ramp_exp = '{24'h7FFFFE, 24'h7FFFFF, 24'h800000, 24'h800001};
        // Seed, then two hand-stepped Galois successors (mask E10000).
        lfsr_exp = '{24'hACE1F5, 24'hB770FA, 24'h5BB87D};

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 2'd0; period = 16'd0; count = 16'd0; amplitude = '0;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle", {5'b0, input_sig, ready, busy, done}, 32'd0);
            tick;
        end

        mode = 2'd0; amplitude = 24'h100000; period = 16'd0; count = 16'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("impulse_ctl", {ready, busy, done}, 3'b110);
            chk("impulse_sig", input_sig, imp_exp[i]);
            tick;
        end
        chk("impulse_done", {ready, busy, done}, 3'b001);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_in_done_ignored", {ready, busy, done}, 3'b000);

        mode = 2'd2; amplitude = 24'h7FFFFE; period = 16'd2; count = 16'd4;
        start = 1'b1;
        tick;
        start = 1'b0;
        idx = 0;
        for (int c = 1; c <= 10; c++) begin
            if ((c - 1) % 3 == 0) begin
                chk("ramp_strobe", {ready, busy, done}, 3'b110);
                chk("ramp_sig", input_sig, ramp_exp[idx]);
                idx++;
            end else begin
                chk("ramp_gap", {ready, busy, done}, 3'b010);
                chk("ramp_hold", input_sig, ramp_exp[idx-1]);
            end
            tick;
        end
        chk("ramp_done", {ready, busy, done}, 3'b001);
        tick;
        chk("ramp_after_done", {ready, busy, done}, 3'b000);

        for (int b = 0; b < 2; b++) begin
            mode = 2'd3; period = 16'd0; count = 16'd3;
            start = 1'b1;
            tick;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("lfsr_ctl", {ready, busy, done}, 3'b110);
                chk("lfsr_sig", input_sig, lfsr_exp[i]);
                tick;
            end
            chk("lfsr_done", {ready, busy, done}, 3'b001);
            tick;
        end

        mode = 2'd1; amplitude = 24'h123456; period = 16'd1; count = 16'd10;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("stop_strobe1", {ready, busy, done}, 3'b110);
        chk("stop_sig1", input_sig, 24'h123456);
        tick;
        mode = 2'd0; amplitude = 24'h000777; start = 1'b1;
        chk("stop_gap1", {ready, busy, done}, 3'b010);
        tick;
        start = 1'b0;
        chk("stop_strobe2", {ready, busy, done}, 3'b110);
        chk("start_in_run_ignored", input_sig, 24'h123456);
        tick;
        chk("stop_gap2", {ready, busy, done}, 3'b010);
        tick;
        chk("stop_strobe3", {ready, busy, done}, 3'b110);
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("stop_idle", {ready, busy, done}, 3'b000);
        chk("stop_hold_sig", input_sig, 24'h123456);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("stop_no_more", {ready, busy, done}, 3'b000);
        end

        mode = 2'd1; amplitude = 24'h123456; period = 16'd1; count = 16'd10;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("rst_strobe1", {ready, busy, done}, 3'b110);
        tick;
        tick;
        chk("rst_strobe2", {ready, busy, done}, 3'b110);
        tick;
        tick;
        chk("rst_strobe3", {ready, busy, done}, 3'b110);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_burst", {5'b0, input_sig, ready, busy, done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("rst_no_more", {ready, busy, done}, 3'b000);
        end

`ifdef FIR_SOURCE_CONTINUOUS_EN
        mode = 2'd2; amplitude = '0; period = 16'd0; count = 16'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            chk("cont_ctl", {ready, busy, done}, 3'b110);
            chk("cont_sig", input_sig, i);
            tick;
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("cont_stop", {ready, busy, done}, 3'b000);
`else
        mode = 2'd0; amplitude = 24'h100000; period = 16'd0; count = 16'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("count0_done", {ready, busy, done}, 3'b001);
        tick;
        chk("count0_after", {ready, busy, done}, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_source.md
Name: fir_sample_source

Overview:
Programmable stimulus transmitter that drives the sample interface of the FIR filter instances (input_sig plus a one-cycle ready strobe).
It emits a burst of signed samples at a programmed cadence, using one of four patterns: impulse, step, ramp or LFSR noise.
It sits upstream of the filter socket and replaces external sample feeds in on-chip and bench comparisons of the direct and separable filters.

Parameters:
WIDTH, 24, sample width in bits (two's complement)
LFSR_SEED, 24'hACE1F5, nonzero 24-bit reset and start seed for noise mode

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to begin a burst; honoured only in IDLE
stop  input  1  abort the running burst; honoured in RUN
mode  input  2  pattern: 0 impulse, 1 step, 2 ramp, 3 LFSR
period  input  16  cycles between strobes minus 1 (0 = every cycle)
count  input  16  number of samples in the burst
amplitude  input  WIDTH  signed level for impulse/step; ramp start value
input_sig  output  WIDTH  signed sample to the filter; registered
ready  output  1  one-cycle strobe: input_sig valid this cycle
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the burst completes normally

Behaviour:
- Reset (rst high at a posedge):
  - input_sig=0, ready=0, busy=0, done=0.
  - State IDLE, divider=0, sample counter=0, LFSR=LFSR_SEED.
  - rst overrides start/stop in the same cycle.
  - rst mid-burst abandons the burst with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode, period, count and amplitude, loads LFSR=LFSR_SEED, clears ramp and sample counters.
  - If count≠0: next state RUN, busy=1 from the next cycle.
  - If count=0: next state DONE (see Optional Feature).
  - start is ignored in RUN and DONE; latched config is unaffected by input changes until the next accepted start.
- RUN:
  - First strobe: ready=1 in the first RUN cycle, i.e. one cycle after start is sampled.
  - Following strobes: every period+1 cycles; the divider counts 0..period and wraps.
  - On each strobe, input_sig is updated with the pattern value for sample index k (0-based):
    - impulse: amplitude at k=0, else 0
    - step: amplitude for all k
    - ramp: amplitude + k, wrapping modulo 2^WIDTH with no saturation
    - LFSR: 24-bit Galois LFSR, polynomial x^24+x^23+x^22+x^17+1, advanced once per strobe. Output is the current state before advancing, sign-extended or truncated to WIDTH. First sample = LFSR_SEED.
  - input_sig holds its value between strobes.
  - After the strobe of sample count-1: next state DONE.
- DONE: done=1 for exactly one cycle, busy=0, ready=0, then IDLE.
  - A start asserted during DONE is ignored; it must be reasserted in IDLE.
- stop in RUN:
  - Next state IDLE, busy=0, no done pulse.
  - If stop coincides with a strobe cycle, that strobe is still emitted, and no further strobes follow.
  - stop in IDLE or DONE has no effect.
- Back-to-back bursts: minimum gap is 1 IDLE cycle (start at the cycle after done).

Optional Feature:
Macro FIR_SOURCE_CONTINUOUS_EN.
- Defined: count=0 means endless burst. RUN continues until stop or rst, and done never pulses. The ramp wraps freely and the LFSR runs its full period.
- Not defined: count=0 at start goes IDLE→DONE directly, giving one done pulse with no ready strobe.

Test Plan:
- Reset then idle: rst high 2 cycles, release, hold start=0 for 20 cycles → input_sig=0, ready=0, busy=0, done=0 throughout.
- Impulse: mode=0, amplitude=24'h100000, period=0, count=4, start at cycle T → ready high T+1..T+4; input_sig=24'h100000, 0, 0, 0; done pulse at T+5; busy low at T+5.
- Ramp with cadence and wrap: mode=2, amplitude=24'h7FFFFE, period=2, count=4 → strobes at T+1, T+4, T+7, T+10; samples 7FFFFE, 7FFFFF, 800000, 800001; done at T+11.
- LFSR: mode=3, count=3, period=0 → samples LFSR_SEED, then its first two Galois successors, matching the bench reference model bit-exact; a second identical burst repeats the same three values.
- Abort and reset mid-burst: step burst count=10, period=1, stop on the 3rd strobe cycle → exactly 3 strobes, no done, busy low next cycle. Repeat with rst in place of stop → outputs zero next cycle, no further strobe.
- count=0: without macro → done pulse at T+1, no ready. With FIR_SOURCE_CONTINUOUS_EN, period=0 → ready every cycle for 1000 cycles until stop, done never asserted.
